// File: rtl/mc_controller_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_controller_if: control/status bundle for the multicycle FSM.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface mc_controller_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       aluZero;
  logic       memReady;
  logic       memReq;
  logic       memWe;
  logic       iorD;
  logic       irWe;
  logic       pcWe;
  logic [1:0] pcSrcCtrl;
  logic       regWe;
  logic [1:0] regDstCtrl;
  logic [1:0] regDInCtrl;
  logic       aluASrcCtrl;
  logic [1:0] aluBSrcCtrl;
  logic [2:0] aluOp;
  logic       instrDone;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  opcode, funct, aluZero, memReady,
    output memReq, memWe, iorD, irWe, pcWe, pcSrcCtrl, regWe, regDstCtrl,
           regDInCtrl, aluASrcCtrl, aluBSrcCtrl, aluOp, instrDone, illegal, state
  );

  modport slave (
    output opcode, funct, aluZero, memReady,
    input  memReq, memWe, iorD, irWe, pcWe, pcSrcCtrl, regWe, regDstCtrl,
           regDInCtrl, aluASrcCtrl, aluBSrcCtrl, aluOp, instrDone, illegal, state
  );
endinterface
`default_nettype wire

// File: rtl/mc_controller.sv
`default_nettype none
// +------------------------------------------------------------------+
// | mc_controller: multicycle control FSM for the MIPS-subset core.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module mc_controller #(
  parameter logic [4:0] LINK_REG        = 5'd31,
  parameter bit         TRAP_ON_ILLEGAL = 1'b1
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mc_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_JREG     = 4'd11,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_addi  = 6'h08;
  localparam logic [5:0] c_op_xori  = 6'h0E;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;
  localparam logic [5:0] c_fn_add   = 6'h20;
  localparam logic [5:0] c_fn_sub   = 6'h22;
  localparam logic [5:0] c_fn_slt   = 6'h2A;
  localparam logic [5:0] c_fn_jr    = 6'h08;

  localparam logic [2:0] c_alu_add  = 3'd0;
  localparam logic [2:0] c_alu_sub  = 3'd1;
  localparam logic [2:0] c_alu_xor  = 3'd2;
  localparam logic [2:0] c_alu_slt  = 3'd3;

  // A link register of $zero would discard the write, so JAL then skips it.
  localparam bit c_link_writes = (LINK_REG != 5'd0);

  state_e state_q, state_d;

  logic w_rtype, w_r_alu, w_jr, w_itype, w_mem, w_bne, w_jump, w_legal;

  assign w_rtype = (bus.opcode == c_op_rtype);
  assign w_r_alu = w_rtype && ((bus.funct == c_fn_add) || (bus.funct == c_fn_sub) ||
                               (bus.funct == c_fn_slt));
  assign w_jr    = w_rtype && (bus.funct == c_fn_jr);
  assign w_itype = (bus.opcode == c_op_addi) || (bus.opcode == c_op_xori);
  assign w_mem   = (bus.opcode == c_op_lw) || (bus.opcode == c_op_sw);
  assign w_bne   = (bus.opcode == c_op_bne);
  assign w_jump  = (bus.opcode == c_op_j) || (bus.opcode == c_op_jal);
  assign w_legal = w_r_alu || w_jr || w_itype || w_mem || w_bne || w_jump;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    state_d = bus.memReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (w_r_alu)              state_d = S_EXEC_R;
        else if (w_jr)            state_d = S_JREG;
        else if (w_itype)         state_d = S_EXEC_I;
        else if (w_mem)           state_d = S_MEM_ADDR;
        else if (w_bne)           state_d = S_BRANCH;
        else if (w_jump)          state_d = S_JUMP;
        else if (TRAP_ON_ILLEGAL) state_d = S_HALT;
        else                      state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (bus.opcode == c_op_lw) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = bus.memReady ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR:   state_d = bus.memReady ? S_FETCH : S_MEM_WR;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Outputs are a pure decode of the state; reset masks them so nothing commits.
  always_comb begin
    bus.memReq      = 1'b0;
    bus.memWe       = 1'b0;
    bus.iorD        = 1'b0;
    bus.irWe        = 1'b0;
    bus.pcWe        = 1'b0;
    bus.pcSrcCtrl   = 2'd0;
    bus.regWe       = 1'b0;
    bus.regDstCtrl  = 2'd0;
    bus.regDInCtrl  = 2'd0;
    bus.aluASrcCtrl = 1'b0;
    bus.aluBSrcCtrl = 2'd0;
    bus.aluOp       = c_alu_add;
    bus.instrDone   = 1'b0;
    bus.illegal     = 1'b0;
    bus.state       = 4'd0;
    if (!reset) begin
      bus.state = state_q;
      case (state_q)
        S_FETCH: begin
          bus.memReq      = 1'b1;
          bus.aluBSrcCtrl = 2'd1;
          bus.irWe        = bus.memReady;
          bus.pcWe        = bus.memReady;
        end
        S_DECODE: begin
          bus.aluBSrcCtrl = 2'd3;
          bus.instrDone   = !w_legal && !TRAP_ON_ILLEGAL;
        end
        S_EXEC_R: begin
          bus.aluASrcCtrl = 1'b1;
          if (bus.funct == c_fn_sub)      bus.aluOp = c_alu_sub;
          else if (bus.funct == c_fn_slt) bus.aluOp = c_alu_slt;
        end
        S_EXEC_I: begin
          bus.aluASrcCtrl = 1'b1;
          bus.aluBSrcCtrl = 2'd2;
          if (bus.opcode == c_op_xori) bus.aluOp = c_alu_xor;
        end
        S_WB_ALU: begin
          bus.regWe      = 1'b1;
          bus.regDstCtrl = w_rtype ? 2'd1 : 2'd0;
          bus.instrDone  = 1'b1;
        end
        S_MEM_ADDR: begin
          bus.aluASrcCtrl = 1'b1;
          bus.aluBSrcCtrl = 2'd2;
        end
        S_MEM_RD: begin
          bus.memReq = 1'b1;
          bus.iorD   = 1'b1;
        end
        S_MEM_WR: begin
          bus.memReq    = 1'b1;
          bus.memWe     = 1'b1;
          bus.iorD      = 1'b1;
          bus.instrDone = bus.memReady;
        end
        S_WB_MEM: begin
          bus.regWe      = 1'b1;
          bus.regDInCtrl = 2'd1;
          bus.instrDone  = 1'b1;
        end
        S_BRANCH: begin
          bus.aluASrcCtrl = 1'b1;
          bus.aluOp       = c_alu_sub;
          bus.pcSrcCtrl   = 2'd3;
          bus.pcWe        = !bus.aluZero;
          bus.instrDone   = 1'b1;
        end
        S_JUMP: begin
          bus.pcWe      = 1'b1;
          bus.pcSrcCtrl = 2'd1;
          bus.instrDone = 1'b1;
          if (bus.opcode == c_op_jal) begin
            bus.regWe      = c_link_writes;
            bus.regDstCtrl = 2'd2;
            bus.regDInCtrl = 2'd2;
          end
        end
        S_JREG: begin
          bus.pcWe      = 1'b1;
          bus.pcSrcCtrl = 2'd2;
          bus.instrDone = 1'b1;
        end
        S_HALT:  bus.illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle control FSM for the MIPS-subset CPU. It sequences a shared-datapath core: one memory port for instruction and data, one ALU reused for PC increment, branch target and execute, and IR/ALUOut/MDR holding registers. It takes the latched opcode/funct, the ALU zero flag and a memory-ready handshake, and drives every datapath enable and mux select. The memory controller and the multicycle cpu top instantiate it.

Parameters:
LINK_REG, 31, register index written by JAL (5 bits).
TRAP_ON_ILLEGAL, 1, 1: an unknown opcode/funct enters HALT; 0: it is retired as a NOP.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; returns the FSM to FETCH.
opcode  in  6  IR[31:26], valid from DECODE onward.
funct  in  6  IR[5:0].
aluZero  in  1  ALU zero flag, combinational.
memReady  in  1  memory completes the current request this cycle.
memReq  out  1  memory access request.
memWe  out  1  memory write strobe; qualified by memReady.
iorD  out  1  memory address select: 0=pc, 1=aluOut.
irWe  out  1  load IR from memory data.
pcWe  out  1  PC load enable.
pcSrcCtrl  out  2  0=ALU result, 1=jump target {pc[31:28],jAddr,00}, 2=regAOut, 3=aluOut register.
regWe  out  1  register-file write enable.
regDstCtrl  out  2  0=rt, 1=rd, 2=LINK_REG.
regDInCtrl  out  2  0=aluOut, 1=MDR, 2=pc.
aluASrcCtrl  out  1  0=pc, 1=regAOut.
aluBSrcCtrl  out  2  0=regBOut, 1=constant 4, 2=sign-extended imm, 3=sign-extended imm<<2.
aluOp  out  3  ALU command: ADD=0, SUB=1, XOR=2, SLT=3.
instrDone  out  1  one-cycle pulse in the retiring cycle of each instruction.
illegal  out  1  high while in HALT.
state  out  4  current state, for debug.

Behaviour:
- Moore FSM. Outputs decode from state, plus memReady/aluZero where noted. Any output not listed for a state is 0.
- Reset: async, state=FETCH. All outputs are forced to 0 while reset is high. No write commits during reset, so an instruction interrupted mid-flight is abandoned with no side effects.
- Encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JUMP=10, JREG=11, HALT=15.
- FETCH: memReq=1, iorD=0, aluA=pc, aluB=4, aluOp=ADD, pcSrc=0. irWe and pcWe assert only when memReady=1, then go to DECODE. Otherwise stay in FETCH with requests held and no PC/IR change.
- DECODE: aluA=pc (already +4), aluB=3, ADD; the branch target is latched into aluOut. Next state by opcode:
  - 0x00 with funct 0x20/0x22/0x2A goes to EXEC_R; funct 0x08 goes to JREG.
  - 0x08 ADDI and 0x0E XORI go to EXEC_I.
  - 0x23 LW and 0x2B SW go to MEM_ADDR.
  - 0x05 BNE goes to BRANCH.
  - 0x02 J and 0x03 JAL go to JUMP.
  - Anything else goes to HALT if TRAP_ON_ILLEGAL=1. Otherwise it goes to FETCH with instrDone=1.
- EXEC_R: aluA=1, aluB=0; aluOp ADD/SUB/SLT for funct 0x20/0x22/0x2A. Then WB_ALU.
- EXEC_I: aluA=1, aluB=2; aluOp ADD for ADDI, XOR for XORI (sign-extended immediate in both cases). Then WB_ALU.
- WB_ALU: regWe=1, regDInCtrl=0; regDst=1 for R-type, 0 for I-type. instrDone=1, then FETCH.
- MEM_ADDR: aluA=1, aluB=2, ADD. LW goes to MEM_RD, SW goes to MEM_WR.
- MEM_RD: memReq=1, iorD=1. Wait on memReady, then WB_MEM.
- MEM_WR: memReq=1, memWe=1, iorD=1. Hold until memReady; exactly one write commits, on the ready cycle. instrDone=1 on that cycle, then FETCH.
- WB_MEM: regWe=1, regDst=0, regDInCtrl=1, instrDone=1, then FETCH.
- BRANCH: aluA=1, aluB=0, SUB, pcSrc=3, pcWe=~aluZero, instrDone=1, then FETCH.
- JUMP: pcWe=1, pcSrc=1. For JAL also regWe=1, regDst=2, regDInCtrl=2, which writes pc+4 because the PC is not yet updated at the edge. instrDone=1, then FETCH.
- JREG: pcWe=1, pcSrc=2, instrDone=1, then FETCH.
- HALT: illegal=1, all enables 0. The FSM stays in HALT until reset.
- Latency with memReady always 1:
  - J/JAL/JR/BNE: 3 cycles.
  - R-type, ADDI/XORI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each memReady=0 cycle in a memory state adds 1 cycle.
- memReady is ignored outside FETCH, MEM_RD and MEM_WR.

Test Plan:
1. Reset mid-MEM_WR with memReady=0, then release → memWe never pulses high with memReady, state=0 after release, all outputs 0 during reset.
2. ADD (op 0x00, funct 0x20), memReady=1 → state sequence 0,1,2,7,0. In WB_ALU: regWe=1, regDst=1, aluOp=0. instrDone pulses once in cycle 4.
3. LW (0x23), memReady low 2 cycles in FETCH and 3 cycles in MEM_RD → 10 cycles total. irWe and pcWe each pulse exactly once. In WB_MEM: regDInCtrl=1, regDst=0.
4. BNE (0x05):
   - aluZero=1 in BRANCH → pcWe=0.
   - aluZero=0 → pcWe=1, pcSrc=3.
   - Both cases retire in 3 cycles.
5. JAL (0x03) → in JUMP: pcWe=1, pcSrc=1, regWe=1, regDst=2, regDInCtrl=2. JR (0x00/0x08) → pcSrc=2, no regWe.
6. Opcode 0x3F:
   - TRAP_ON_ILLEGAL=1 → state=15, illegal=1 held for 20 cycles, memReq=0.
   - TRAP_ON_ILLEGAL=0 → back to FETCH after 2 cycles with instrDone=1, regWe never asserted.
